// File: rtl/modbus_pkg.sv
// Shared Modbus request definitions: function codes, 48-bit frame layout and
// the frame packing helper used by the sequencer.
package modbus_pkg;

  localparam logic [7:0] FUNC_WRITE_SINGLE = 8'h06;
  localparam logic [7:0] FUNC_READ_HOLDING = 8'h03;

  localparam int FRAME_W   = 48;
  localparam int ID_LSB    = 0;
  localparam int FUNC_LSB  = 8;
  localparam int ADDR_LSB  = 16;
  localparam int VALUE_LSB = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [7:0]  id,
    input logic [7:0]  func,
    input logic [15:0] addr,
    input logic [15:0] value
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[ID_LSB    +: 8]  = id;
    f[FUNC_LSB  +: 8]  = func;
    f[ADDR_LSB  +: 16] = addr;
    f[VALUE_LSB +: 16] = value;
    return f;
  endfunction

endpackage

// File: rtl/modbus_frame_sequencer_if.sv
// Valid/ready frame channel between the request sequencer (master) and the
// RS-485 transmitter (slave).
interface modbus_frame_sequencer_if #(
  parameter int IDX_W = 7
);
  import modbus_pkg::*;

  logic [FRAME_W-1:0] data;
  logic               tx_valid;
  logic [IDX_W-1:0]   frame_idx;
  logic               tx_ready;

  modport master (output data, output tx_valid, output frame_idx, input tx_ready);
  modport slave  (input data, input tx_valid, input frame_idx, output tx_ready);

endinterface

// File: rtl/modbus_frame_sequencer_period_tick.sv
// Free-running prescaler: counts 0..PERIOD-1 and flags the last count as the
// launch tick.
module period_tick #(
  parameter int PERIOD = 160000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] count_q;

  assign tick = (count_q == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/modbus_frame_sequencer.sv
// Periodic Modbus request sequencer: one write/read frame per tick, held on a
// valid/ready channel until the transmitter accepts it.
module modbus_frame_sequencer
  import modbus_pkg::*;
#(
  parameter int N_WR      = 10,
  parameter int N_RD      = 10,
  parameter int BASE_ADDR = 300,
  parameter int SLAVE_ID  = 2,
  parameter int PERIOD    = 160000,
  parameter int IDX_W     = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [16*N_WR-1:0]  wr_regs,
  input  logic                overrun_clr,
  output logic                cycle_done,
  output logic                overrun,
  modbus_frame_sequencer_if.master tx
);

  localparam int               N_FRAMES = N_WR + N_RD;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FRAMES - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   frame_idx_q;
  logic [FRAME_W-1:0] data_q;
  logic               cycle_done_q;
  logic               overrun_q;

  logic               tick;
  logic [7:0]         func_d;
  logic [15:0]        addr_d;
  logic [15:0]        value_d;
  logic [FRAME_W-1:0] frame_d;

  period_tick #(.PERIOD(PERIOD)) u_period_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Frame for the current index; write slots take the live register value,
  // which is captured only on the launch edge.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    func_d  = FUNC_READ_HOLDING;
    value_d = 16'd1;
    for (int k = 0; k < N_WR; k++) begin
      if (idx_q == IDX_W'(k)) begin
        func_d  = FUNC_WRITE_SINGLE;
        value_d = wr_regs[16*k +: 16];
      end
    end
    addr_d  = 16'(BASE_ADDR) + 16'(idx_q);
    frame_d = build_frame(8'(SLAVE_ID), func_d, addr_d, value_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      frame_idx_q  <= '0;
      data_q       <= '0;
      cycle_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge state.
      cycle_done_q <= 1'b0;

      // A tick that finds a frame still pending is dropped; set beats clear.
      if (tick && (state_q == ST_SEND)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (tick && enable) begin
            state_q     <= ST_SEND;
            data_q      <= frame_d;
            frame_idx_q <= idx_q;
          end
        end
        ST_SEND: begin
          if (tx.tx_ready) begin
            state_q      <= ST_IDLE;
            cycle_done_q <= (idx_q == LAST_IDX);
            idx_q        <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx.data      = data_q;
  assign tx.tx_valid  = (state_q == ST_SEND);
  assign tx.frame_idx = frame_idx_q;
  assign cycle_done   = cycle_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_modbus_frame_sequencer.sv
// Bench for modbus_frame_sequencer: vector table, directed corner sequences,
// randomized run against a frame-level reference model, writes-only instance.
module tb_modbus_frame_sequencer;

  localparam int P_A  = 8;
  localparam int NW_A = 2;
  localparam int NR_A = 1;
  localparam int NF_A = NW_A + NR_A;
  localparam int P_B  = 4;
  localparam int NW_B = 3;

  localparam logic [47:0] F0 = 48'h1234_012C_06_02;
  localparam logic [47:0] F1 = 48'hBEEF_012D_06_02;
  localparam logic [47:0] F2 = 48'h0001_012E_03_02;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a, clr_a, done_a, ovr_a;
  logic [31:0] wr_a;
  logic        en_b, clr_b, done_b, ovr_b;
  logic [47:0] wr_b;

  modbus_frame_sequencer_if #(.IDX_W(7)) bus_a ();
  modbus_frame_sequencer_if #(.IDX_W(7)) bus_b ();

  modbus_frame_sequencer #(
    .N_WR(NW_A), .N_RD(NR_A), .BASE_ADDR(300), .SLAVE_ID(2), .PERIOD(P_A), .IDX_W(7)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .wr_regs(wr_a), .overrun_clr(clr_a),
    .cycle_done(done_a), .overrun(ovr_a), .tx(bus_a.master)
  );

  modbus_frame_sequencer #(
    .N_WR(NW_B), .N_RD(0), .BASE_ADDR(300), .SLAVE_ID(2), .PERIOD(P_B), .IDX_W(7)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .wr_regs(wr_b), .overrun_clr(clr_b),
    .cycle_done(done_b), .overrun(ovr_b), .tx(bus_b.master)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Reference model for dut_a, stepped once per clock from the applied inputs.
  int          m_cnt, m_idx, m_fidx;
  bit          m_busy, m_ovr, m_done;
  logic [47:0] m_data;

  typedef struct {
    int          cyc;
    logic        en;
    logic        rdy;
    logic        valid;
    logic [47:0] data;
    int          idx;
    logic        done;
    logic        ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [47:0] ref_frame(input int i, input logic [31:0] wr);
    logic [15:0] val;
    logic [7:0]  fn;
    logic [15:0] addr;
    addr = 16'((300 + i) % 65536);
    if (i < NW_A) begin
      val = wr[16*i +: 16];
      fn  = 8'h06;
    end else begin
      val = 16'd1;
      fn  = 8'h03;
    end
    return {val, addr, fn, 8'h02};
  endfunction

  task automatic model_step();
    bit tk;
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_fidx = 0;
      m_busy = 0; m_ovr = 0; m_done = 0; m_data = '0;
    end else begin
      tk = ((m_cnt % P_A) == P_A - 1);
      m_done = 0;
      if (clr_a) m_ovr = 0;
      if (tk && m_busy) m_ovr = 1;
      if (m_busy) begin
        if (bus_a.tx_ready) begin
          m_busy = 0;
          m_done = (m_idx == NF_A - 1);
          m_idx  = (m_idx + 1) % NF_A;
        end
      end else if (tk && en_a) begin
        m_busy = 1;
        m_data = ref_frame(m_idx, wr_a);
        m_fidx = m_idx;
      end
      m_cnt++;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_a(input string tag, input logic v, input logic [47:0] d,
                         input int idx, input logic dn, input logic ov);
    check({tag, ".valid"}, 64'(bus_a.tx_valid), 64'(v));
    check({tag, ".data"},  64'(bus_a.data),     64'(d));
    check({tag, ".idx"},   64'(bus_a.frame_idx), 64'(idx));
    check({tag, ".done"},  64'(done_a),         64'(dn));
    check({tag, ".ovr"},   64'(ovr_a),          64'(ov));
  endtask

  // Reset for two edges, verify reset outputs, release; cycle 0 starts here.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    check_a("rst_a", 1'b0, 48'h0, 0, 1'b0, 1'b0);
    check("rst_b.valid", 64'(bus_b.tx_valid), 64'(0));
    check("rst_b.data",  64'(bus_b.data),     64'(0));
    step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic add(input int c, input logic en, input logic rdy, input logic v,
                     input logic [47:0] d, input int idx, input logic dn, input logic ov);
    vec_t t;
    t.cyc = c; t.en = en; t.rdy = rdy; t.valid = v;
    t.data = d; t.idx = idx; t.done = dn; t.ovr = ov;
    tbl.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    en_a = 1'b1; clr_a = 1'b0; wr_a = {16'hBEEF, 16'h1234};
    bus_a.tx_ready = 1'b1;
    en_b = 1'b1; clr_b = 1'b0; wr_b = 48'h0C0C_0B0B_0A0A;
    bus_b.tx_ready = 1'b1;

    // Vector table: inputs in a row are applied after that row's compare.
    add(0,  1, 1, 0, 48'h0, 0, 0, 0);
    add(7,  1, 1, 0, 48'h0, 0, 0, 0);
    add(8,  1, 1, 1, F0,    0, 0, 0);
    add(9,  1, 1, 0, F0,    0, 0, 0);
    add(16, 1, 1, 1, F1,    1, 0, 0);
    add(17, 1, 1, 0, F1,    1, 0, 0);
    add(24, 1, 1, 1, F2,    2, 0, 0);
    add(25, 1, 1, 0, F2,    2, 1, 0);
    add(26, 1, 1, 0, F2,    2, 0, 0);
    add(32, 1, 0, 1, F0,    0, 0, 0);
    add(33, 1, 0, 1, F0,    0, 0, 0);
    add(39, 1, 1, 1, F0,    0, 0, 0);
    add(40, 1, 1, 0, F0,    0, 0, 1);
    add(47, 1, 1, 0, F0,    0, 0, 1);
    add(48, 1, 1, 1, F1,    1, 0, 1);

    do_reset();
    foreach (tbl[r]) begin
      run_to(tbl[r].cyc);
      check_a($sformatf("vec%0d", tbl[r].cyc), tbl[r].valid, tbl[r].data,
              tbl[r].idx, tbl[r].done, tbl[r].ovr);
      en_a = tbl[r].en;
      bus_a.tx_ready = tbl[r].rdy;
    end

    // Stalled transmitter: data stability, overrun set/clear, set beats clear.
    en_a = 1'b1; bus_a.tx_ready = 1'b0; clr_a = 1'b0; wr_a = {16'hBEEF, 16'h1234};
    do_reset();
    run_to(8);
    check("stall.launch", 64'(bus_a.tx_valid), 64'(1));
    run_to(10);
    wr_a = 32'hAAAA_5555;
    run_to(15);
    check("stall.data15", 64'(bus_a.data), 64'(F0));
    check("stall.ovr15", 64'(ovr_a), 64'(0));
    run_to(16);
    check("stall.ovr16", 64'(ovr_a), 64'(1));
    check("stall.idx16", 64'(bus_a.frame_idx), 64'(0));
    run_to(17);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("stall.clr", 64'(ovr_a), 64'(0));
    run_to(23);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("stall.set_wins", 64'(ovr_a), 64'(1));
    run_to(27);
    check("stall.data27", 64'(bus_a.data), 64'(F0));
    check("stall.valid27", 64'(bus_a.tx_valid), 64'(1));
    run_to(28);
    bus_a.tx_ready = 1'b1;
    step();
    check("stall.accept", 64'(bus_a.tx_valid), 64'(0));
    run_to(32);
    check_a("stall.next", 1'b1, 48'hAAAA_012D_06_02, 1, 1'b0, 1'b1);

    // Enable dropped mid-frame, then restored; then reset during SEND.
    en_a = 1'b1; bus_a.tx_ready = 1'b0; wr_a = {16'hBEEF, 16'h1234};
    do_reset();
    run_to(9);
    en_a = 1'b0;
    run_to(12);
    check("en.held", 64'(bus_a.data), 64'(F0));
    check("en.valid12", 64'(bus_a.tx_valid), 64'(1));
    bus_a.tx_ready = 1'b1;
    step();
    check("en.accept", 64'(bus_a.tx_valid), 64'(0));
    run_to(24);
    check("en.no_launch", 64'(bus_a.tx_valid), 64'(0));
    run_to(30);
    en_a = 1'b1;
    run_to(32);
    check_a("en.resume", 1'b1, F1, 1, 1'b0, 1'b0);
    bus_a.tx_ready = 1'b0;
    step();
    check("rstmid.pending", 64'(bus_a.tx_valid), 64'(1));
    bus_a.tx_ready = 1'b1;
    do_reset();
    run_to(7);
    check("rstmid.quiet7", 64'(bus_a.tx_valid), 64'(0));
    run_to(8);
    check_a("rstmid.first", 1'b1, F0, 0, 1'b0, 1'b0);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      en_a           = ($urandom_range(0, 9) != 0);
      bus_a.tx_ready = ($urandom_range(0, 2) == 0);
      clr_a          = ($urandom_range(0, 15) == 0);
      wr_a           = $urandom();
      step();
      check_a("rnd", 1'(m_busy), m_data, m_fidx, 1'(m_done), 1'(m_ovr));
    end
    rst_n = 1'b1; clr_a = 1'b0;

    // Writes-only instance: addresses 300..302, cycle_done every third frame.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      run_to(P_B * (k + 1));
      check($sformatf("wo%0d.valid", k), 64'(bus_b.tx_valid), 64'(1));
      check($sformatf("wo%0d.data", k), 64'(bus_b.data),
            64'({wr_b[16*(k%3) +: 16], 16'(300 + k % 3), 8'h06, 8'h02}));
      check($sformatf("wo%0d.idx", k), 64'(bus_b.frame_idx), 64'(k % 3));
      step();
      check($sformatf("wo%0d.fall", k), 64'(bus_b.tx_valid), 64'(0));
      check($sformatf("wo%0d.done", k), 64'(done_b), 64'((k % 3) == 2));
    end
    check("wo.ovr", 64'(ovr_b), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
